// File: rtl/snake_crash_monitor.sv
// rtl/snake_crash_monitor.sv - per-frame head overlap counter with multi-frame crash confirmation
module snake_crash_monitor #(
  parameter int H_LAST         = 639,
  parameter int V_LAST         = 479,
  parameter int HIT_MIN        = 4,
  parameter int CONFIRM_FRAMES = 2,
  parameter int CNT_W          = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             restart,
  input  logic             pixel_tick,
  input  logic             video_on,
  input  logic [9:0]       pixel_x,
  input  logic [9:0]       pixel_y,
  input  logic             obstacle_region,
  input  logic             head_region,
  input  logic             body_region,
  output logic             crashed,
  output logic [1:0]       crash_cause,
  output logic             frame_done,
  output logic [CNT_W-1:0] obs_hits
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_SCAN,
    S_EVAL,
    S_CRASHED
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] obs_cnt_q, obs_cnt_d;
  logic [CNT_W-1:0] body_cnt_q, body_cnt_d;
  logic [3:0]       consec_q, consec_d;
  logic [1:0]       pend_q, pend_d;
  logic             crashed_q, crashed_d;
  logic [1:0]       crash_cause_q, crash_cause_d;
  logic             frame_done_q, frame_done_d;
  logic [CNT_W-1:0] obs_hits_q, obs_hits_d;

  logic             first_px, last_px;
  logic             obs_inc, body_inc;
  logic [CNT_W-1:0] obs_cnt_inc, body_cnt_inc;
  logic             obs_hit, body_hit, any_hit;
  logic [3:0]       consec_next;
  logic [1:0]       pend_next;

  assign first_px     = (pixel_x == 10'd0) && (pixel_y == 10'd0);
  assign last_px      = (pixel_x == 10'(H_LAST)) && (pixel_y == 10'(V_LAST));
  assign obs_inc      = pixel_tick && video_on && head_region && obstacle_region;
  assign body_inc     = pixel_tick && video_on && head_region && body_region;
  // Counters stick at all-ones so a huge overlap can never wrap below HIT_MIN.
  assign obs_cnt_inc  = (obs_cnt_q  == '1) ? obs_cnt_q  : obs_cnt_q  + 1'b1;
  assign body_cnt_inc = (body_cnt_q == '1) ? body_cnt_q : body_cnt_q + 1'b1;
  assign obs_hit      = obs_cnt_q  >= CNT_W'(HIT_MIN);
  assign body_hit     = body_cnt_q >= CNT_W'(HIT_MIN);
  assign any_hit      = obs_hit || body_hit;
  assign consec_next  = !any_hit ? 4'd0 :
                        (consec_q >= 4'(CONFIRM_FRAMES)) ? 4'(CONFIRM_FRAMES) : consec_q + 4'd1;
  assign pend_next    = any_hit ? (pend_q | {body_hit, obs_hit}) : 2'b00;

  // Next-state and next-output logic; en=0 beats restart, restart beats frame evaluation.
  always_comb begin
    state_d       = state_q;
    obs_cnt_d     = obs_cnt_q;
    body_cnt_d    = body_cnt_q;
    consec_d      = consec_q;
    pend_d        = pend_q;
    crashed_d     = crashed_q;
    crash_cause_d = crash_cause_q;
    frame_done_d  = 1'b0;
    obs_hits_d    = obs_hits_q;

    if (!en) begin
      state_d    = S_IDLE;
      obs_cnt_d  = '0;
      body_cnt_d = '0;
      consec_d   = 4'd0;
      pend_d     = 2'b00;
      if (restart) begin
        crashed_d     = 1'b0;
        crash_cause_d = 2'b00;
      end
    end else if (restart) begin
      state_d       = S_WAIT_SOF;
      obs_cnt_d     = '0;
      body_cnt_d    = '0;
      consec_d      = 4'd0;
      pend_d        = 2'b00;
      crashed_d     = 1'b0;
      crash_cause_d = 2'b00;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_WAIT_SOF;
        S_WAIT_SOF: begin
          if (pixel_tick && first_px) begin
            state_d = S_SCAN;
            if (obs_inc)  obs_cnt_d  = obs_cnt_inc;
            if (body_inc) body_cnt_d = body_cnt_inc;
          end
        end
        S_SCAN: begin
          if (obs_inc)  obs_cnt_d  = obs_cnt_inc;
          if (body_inc) body_cnt_d = body_cnt_inc;
          if (pixel_tick && last_px) state_d = S_EVAL;
        end
        S_EVAL: begin
          consec_d     = consec_next;
          pend_d       = pend_next;
          obs_hits_d   = obs_cnt_q;
          obs_cnt_d    = '0;
          body_cnt_d   = '0;
          frame_done_d = 1'b1;
          if (consec_next == 4'(CONFIRM_FRAMES)) begin
            crashed_d     = 1'b1;
            crash_cause_d = pend_next;
            state_d       = S_CRASHED;
          end else begin
            state_d = S_SCAN;
          end
        end
        S_CRASHED: state_d = S_CRASHED;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      obs_cnt_q     <= '0;
      body_cnt_q    <= '0;
      consec_q      <= 4'd0;
      pend_q        <= 2'b00;
      crashed_q     <= 1'b0;
      crash_cause_q <= 2'b00;
      frame_done_q  <= 1'b0;
      obs_hits_q    <= '0;
    end else begin
      state_q       <= state_d;
      obs_cnt_q     <= obs_cnt_d;
      body_cnt_q    <= body_cnt_d;
      consec_q      <= consec_d;
      pend_q        <= pend_d;
      crashed_q     <= crashed_d;
      crash_cause_q <= crash_cause_d;
      frame_done_q  <= frame_done_d;
      obs_hits_q    <= obs_hits_d;
    end
  end

  assign crashed     = crashed_q;
  assign crash_cause = crash_cause_q;
  assign frame_done  = frame_done_q;
  assign obs_hits    = obs_hits_q;

endmodule

// File: tb/tb_snake_crash_monitor.sv
// tb/tb_snake_crash_monitor.sv - randomized and directed bench for snake_crash_monitor with frame-level model
module tb_snake_crash_monitor;

  localparam int H_LAST  = 31;
  localparam int V_LAST  = 15;
  localparam int H_TOT   = 34;
  localparam int V_TOT   = 17;
  localparam int HIT_MIN = 4;
  localparam int CONF    = 2;
  localparam int CNT_W   = 12;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b0;
  logic             restart = 1'b0;
  logic             pixel_tick = 1'b0;
  logic             video_on = 1'b0;
  logic [9:0]       pixel_x = '0;
  logic [9:0]       pixel_y = '0;
  logic             obstacle_region = 1'b0;
  logic             head_region = 1'b0;
  logic             body_region = 1'b0;
  logic             crashed;
  logic [1:0]       crash_cause;
  logic             frame_done;
  logic [CNT_W-1:0] obs_hits;

  snake_crash_monitor #(
    .H_LAST(H_LAST), .V_LAST(V_LAST), .HIT_MIN(HIT_MIN),
    .CONFIRM_FRAMES(CONF), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .restart(restart),
    .pixel_tick(pixel_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .obstacle_region(obstacle_region), .head_region(head_region), .body_region(body_region),
    .crashed(crashed), .crash_cause(crash_cause), .frame_done(frame_done), .obs_hits(obs_hits)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: where the monitor is in the frame, accumulated overlap, hit streak.
  int   m_obs, m_body, m_streak;
  logic [1:0] m_acc;
  bit   m_armed, m_inframe, m_evalnow, m_locked;
  bit   e_crashed, e_fd;
  logic [1:0] e_cause;
  int   e_hits;

  task automatic m_clear();
    m_obs = 0; m_body = 0; m_streak = 0; m_acc = 2'b00;
    m_armed = 0; m_inframe = 0; m_evalnow = 0; m_locked = 0;
  endtask

  task automatic m_count();
    if (pixel_tick && video_on && head_region && obstacle_region && m_obs < CNT_MAX) m_obs++;
    if (pixel_tick && video_on && head_region && body_region && m_body < CNT_MAX) m_body++;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_clear();
      e_crashed = 0; e_cause = 2'b00; e_fd = 0; e_hits = 0;
    end else begin
      e_fd = 0;
      if (!en) begin
        m_clear();
        if (restart) begin e_crashed = 0; e_cause = 2'b00; end
      end else if (restart) begin
        m_clear();
        m_armed = 1;
        e_crashed = 0; e_cause = 2'b00;
      end else if (m_locked) begin
      end else if (m_evalnow) begin
        bit ho, hb;
        ho = m_obs >= HIT_MIN;
        hb = m_body >= HIT_MIN;
        if (ho || hb) begin
          if (m_streak < CONF) m_streak++;
          m_acc = m_acc | {hb, ho};
        end else begin
          m_streak = 0; m_acc = 2'b00;
        end
        e_fd = 1; e_hits = m_obs;
        m_obs = 0; m_body = 0; m_evalnow = 0;
        if (m_streak == CONF) begin
          e_crashed = 1; e_cause = m_acc; m_locked = 1;
        end else begin
          m_inframe = 1;
        end
      end else if (m_inframe) begin
        m_count();
        if (pixel_tick && pixel_x == 10'(H_LAST) && pixel_y == 10'(V_LAST)) begin
          m_inframe = 0; m_evalnow = 1;
        end
      end else if (m_armed) begin
        if (pixel_tick && pixel_x == 10'd0 && pixel_y == 10'd0) begin
          m_count();
          m_armed = 0; m_inframe = 1;
        end
      end else begin
        m_armed = 1;
      end
    end
  end

  // Cycle compare against the model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("crashed", int'(crashed), int'(e_crashed));
      chk("crash_cause", int'(crash_cause), int'(e_cause));
      chk("frame_done", int'(frame_done), int'(e_fd));
      chk("obs_hits", int'(obs_hits), e_hits);
    end
  end

  int fd_count = 0;
  int fd_hits = 0;
  int fd_crashed = 0;
  int fd_cause = 0;
  always @(negedge clk) begin
    if (!reset && frame_done) begin
      fd_count++;
      fd_hits = int'(obs_hits);
      fd_crashed = int'(crashed);
      fd_cause = int'(crash_cause);
    end
  end

  task automatic idle(input int n);
    pixel_tick = 0; restart = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_pixel(input int x, input int y, input bit hd, input bit ob,
                             input bit bd, input bit von, input bit rs);
    int gap;
    gap = $urandom_range(1, 2);
    repeat (gap) begin
      pixel_tick = 0; restart = 0;
      pixel_x = 10'($urandom_range(0, 1023)); pixel_y = 10'($urandom_range(0, 1023));
      head_region = 1; obstacle_region = 1; body_region = 1; video_on = 1;
      @(negedge clk);
    end
    pixel_tick = 1; pixel_x = 10'(x); pixel_y = 10'(y);
    head_region = hd; obstacle_region = ob; body_region = bd; video_on = von; restart = rs;
    @(negedge clk);
    pixel_tick = 0; restart = 0;
    head_region = 0; obstacle_region = 0; body_region = 0;
  endtask

  task automatic run_frame(input int hw, input int hh, input bit fo, input bit fb,
                           input int y0, input int y1, input bit rs_last, input bit noise);
    for (int y = y0; y < y1; y++) begin
      for (int x = 0; x < H_TOT; x++) begin
        bit vis, hd, ob, bd, von, rs;
        vis = (x <= H_LAST) && (y <= V_LAST);
        hd  = vis && (x < hw) && (y < hh);
        ob  = hd ? fo : bit'($urandom_range(0, 1));
        bd  = hd ? fb : bit'($urandom_range(0, 1));
        von = vis && !(noise && $urandom_range(0, 15) == 0);
        rs  = rs_last && (x == H_LAST) && (y == V_LAST);
        drive_pixel(x, y, hd, ob, bd, von, rs);
      end
    end
  endtask

  initial begin
    int fd0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("reset_crashed", int'(crashed), 0);
    chk("reset_cause", int'(crash_cause), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    chk("reset_obs_hits", int'(obs_hits), 0);
    en = 1;

    // 20x16 head/obstacle overlap, two frames
    fd0 = fd_count;
    run_frame(20, 16, 1, 0, 0, V_TOT, 0, 0);
    idle(3);
    chk("t1_f1_done", fd_count, fd0 + 1);
    chk("t1_f1_hits", fd_hits, 320);
    chk("t1_f1_crashed", fd_crashed, 0);
    run_frame(20, 16, 1, 0, 0, V_TOT, 0, 0);
    idle(3);
    chk("t1_f2_crashed", fd_crashed, 1);
    chk("t1_f2_cause", fd_cause, 1);
    chk("t1_f2_hits", fd_hits, 320);

    // restart on a last-pixel tick while crashed
    fd0 = fd_count;
    run_frame(20, 16, 1, 0, 0, V_TOT, 1, 0);
    idle(3);
    chk("t6_crashed", int'(crashed), 0);
    chk("t6_cause", int'(crash_cause), 0);
    chk("t6_no_done", fd_count, fd0);

    // 3-pixel overlap never hits
    fd0 = fd_count;
    repeat (5) run_frame(3, 1, 1, 0, 0, V_TOT, 0, 0);
    idle(3);
    chk("t2_done_count", fd_count, fd0 + 5);
    chk("t2_crashed", int'(crashed), 0);
    chk("t2_hits", int'(obs_hits), 3);

    // hit, clean, hit, hit (4 = HIT_MIN boundary)
    run_frame(4, 1, 1, 0, 0, V_TOT, 0, 0);
    run_frame(0, 0, 0, 0, 0, V_TOT, 0, 0);
    run_frame(4, 1, 1, 0, 0, V_TOT, 0, 0);
    idle(3);
    chk("t3_no_crash", int'(crashed), 0);
    run_frame(4, 1, 1, 0, 0, V_TOT, 0, 0);
    idle(3);
    chk("t3_crash", int'(crashed), 1);
    chk("t3_cause", int'(crash_cause), 1);

    restart = 1; @(negedge clk); restart = 0;
    idle(2);
    chk("restart_clears", int'(crashed), 0);

    // obstacle-only then body-only
    run_frame(2, 2, 1, 0, 0, V_TOT, 0, 0);
    run_frame(5, 1, 0, 1, 0, V_TOT, 0, 0);
    idle(3);
    chk("t4_crash", int'(crashed), 1);
    chk("t4_cause", int'(crash_cause), 3);
    chk("t4_hits", int'(obs_hits), 0);

    // en low keeps crash; en rising mid-frame skips the partial frame
    en = 0;
    idle(4);
    chk("en_low_keeps_crashed", int'(crashed), 1);
    chk("en_low_keeps_cause", int'(crash_cause), 3);
    en = 1;
    fd0 = fd_count;
    run_frame(5, 5, 1, 1, 8, V_TOT, 0, 0);
    idle(3);
    chk("t5_partial_no_done", fd_count, fd0);
    run_frame(0, 0, 0, 0, 0, V_TOT, 0, 0);
    idle(3);
    chk("t5_full_done", fd_count, fd0 + 1);
    chk("t5_crash_kept", int'(crashed), 1);

    // async reset mid-scan, away from any clock edge
    run_frame(0, 0, 0, 0, 0, 8, 0, 0);
    #2 reset = 1;
    #1;
    chk("async_crashed", int'(crashed), 0);
    chk("async_frame_done", int'(frame_done), 0);
    chk("async_cause", int'(crash_cause), 0);
    @(negedge clk);
    reset = 0;

    // randomized frames against the model
    for (int f = 0; f < 12; f++) begin
      bit rs;
      if (f == 6) begin
        run_frame(3, 3, 1, 1, 0, 6, 0, 1);
        en = 0; idle(3); en = 1;
      end
      rs = e_crashed ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      run_frame($urandom_range(0, 5), $urandom_range(0, 3),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                0, V_TOT, rs, 1);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
